div_seq_ctrl: RTL and testbench

- Sequencing controller for the CPU's restoring division datapath.
- Accepts a start request from the ALU/control unit and latches the operands.
- Runs one shift-subtract iteration per clock for WIDTH cycles, then applies sign fix-up.
- Presents the packed 64-bit result {quotient, remainder} for the HI/LO register write with a done pulse. Owns busy/handshake so the control FSM can stall on it.

---
 rtl/div_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencing controller for a restoring divider (one shift-subtract step per clock).
// Latency: WIDTH ITER cycles + 1 FIX cycle + 1 DONE cycle. Divide-by-zero goes straight to DONE.
// Backpressure: none. A start is taken only in IDLE. While busy or in DONE, start is ignored.
//
// Optional build macro: DIV_SIGNED_EN
//   Defined: operands are two's complement, and the sign fix-up is applied in FIX.
//   Undefined: operands are unsigned. FIX passes values through but still takes its cycle.
//
// Ports:
//   i_clock      system clock, all state on the rising edge
//   i_reset      synchronous active-high reset, clears all state
//   i_start      division request, sampled only in IDLE
//   i_dividend   dividend, latched on an accepted start
//   i_divisor    divisor, latched on an accepted start
//   o_busy       high while iterating and during fix-up
//   o_done       single-cycle pulse, o_z/o_dbz valid from this cycle
//   o_dbz        divide-by-zero flag, held until the next accepted start
//   o_z          {quotient, remainder}, held until the next result or reset
module div_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_dbz,
  output logic [2*WIDTH-1:0] o_z
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_dvs;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_z;
  logic               r_dbz;

  logic               w_dvd_neg;
  logic               w_dvs_neg;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic               w_accept;
  logic               w_qsign;
  logic               w_rsign;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

`ifdef DIV_SIGNED_EN
  assign w_dvd_neg = i_dividend[WIDTH-1];
  assign w_dvs_neg = i_divisor[WIDTH-1];
`else
  assign w_dvd_neg = 1'b0;
  assign w_dvs_neg = 1'b0;
`endif

  // The most negative value maps to itself. Read as unsigned, that is the correct magnitude.
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor  : i_divisor;

  assign w_accept = (r_state == S_IDLE) && i_start && (i_divisor != '0);

`ifdef DIV_SIGNED_EN
  logic r_qsign;
  logic r_rsign;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
    end else if (w_accept) begin
      r_qsign <= w_dvd_neg ^ w_dvs_neg;
      r_rsign <= w_dvd_neg;  // remainder follows the dividend's sign
    end
  end

  assign w_qsign = r_qsign;
  assign w_rsign = r_rsign;
`else
  assign w_qsign = 1'b0;
  assign w_rsign = 1'b0;
`endif

  // Restoring step. The shifted partial remainder keeps its top bit.
  // This keeps the comparison exact for divisors with the MSB set.
  // When the comparison passes, the true difference is below r_dvs, so WIDTH bits hold it.
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

  assign w_q_fix = w_qsign ? -r_q   : r_q;
  assign w_r_fix = w_rsign ? -r_rem : r_rem;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_divisor == '0) ? S_DONE : S_ITER;
        end
      end
      S_ITER: begin
        o_busy = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        o_busy      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rem <= '0;
      r_q   <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_z   <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_divisor != '0) begin
              r_rem <= '0;
              r_q   <= w_dvd_mag;
              r_dvs <= w_dvs_mag;
              r_cnt <= CNT_W'(WIDTH);
              r_dbz <= 1'b0;
            end else begin
              r_z   <= {{WIDTH{1'b1}}, i_dividend};
              r_dbz <= 1'b1;
            end
          end
        end
        S_ITER: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_z <= {w_q_fix, w_r_fix};
        end
        default: begin
        end
      endcase
    end
  end

  assign o_z   = r_z;
  assign o_dbz = r_dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed vectors for div_seq_ctrl with hand-computed results.
// Latency is counted in cycles. The cycle in which start is presented counts as cycle 1.
// Outputs are sampled on the falling edge, and inputs are driven there too.
module tb_div_seq_ctrl;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           i_reset;
  logic           i_start;
  logic [W-1:0]   i_dividend;
  logic [W-1:0]   i_divisor;
  logic           o_busy;
  logic           o_done;
  logic           o_dbz;
  logic [2*W-1:0] o_z;

  int n_chk  = 0;
  int n_pass = 0;

  int cyc;
  int bcyc;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_dbz      (o_dbz),
    .o_z        (o_z)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a start with a / b for one cycle, then wait for done (bounded to 100 cycles).
  // pulse_at > 0: re-pulse start with 9/3 on that cycle (it must be ignored).
  // rst_at   > 0: assert reset on that cycle and return.
  // After acceptance the operand inputs are scrambled to show they are not re-sampled.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int pulse_at, input int rst_at,
                        output int c, output int bc);
    @(negedge clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    c  = 0;
    bc = 0;
    while (c < 100) begin
      @(negedge clk);
      i_start    = 1'b0;
      i_dividend = ~a;
      i_divisor  = b ^ 32'h0000_0F0F;
      c++;
      if (o_busy) bc++;
      if (o_done) break;
      if (c == pulse_at) begin
        i_start    = 1'b1;
        i_dividend = 32'd9;
        i_divisor  = 32'd3;
      end
      if (c == rst_at) begin
        i_reset = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_done", 64'(o_done), 64'd0);
    chk("reset_dbz",  64'(o_dbz),  64'd0);
    chk("reset_z",    o_z,         64'd0);
    i_reset = 1'b0;

    // 100 / 7 = 14 r 2
    do_div(32'd100, 32'd7, 0, 0, cyc, bcyc);
    chk("u100_7_latency", 64'(cyc),  64'd34);
    chk("u100_7_busy",    64'(bcyc), 64'd33);
    chk("u100_7_z",       o_z,       64'h0000000E_00000002);
    chk("u100_7_dbz",     64'(o_dbz), 64'd0);
    repeat (2) @(negedge clk);
    chk("u100_7_done_pulse", 64'(o_done), 64'd0);
    chk("u100_7_z_held",     o_z,         64'h0000000E_00000002);

    // 5 / 0: divide by zero
    do_div(32'd5, 32'd0, 0, 0, cyc, bcyc);
    chk("dbz_latency", 64'(cyc),   64'd1);
    chk("dbz_busy",    64'(bcyc),  64'd0);
    chk("dbz_z",       o_z,        64'hFFFFFFFF_00000005);
    chk("dbz_flag",    64'(o_dbz), 64'd1);
    // A start presented during DONE is dropped.
    i_start    = 1'b1;
    i_dividend = 32'd9;
    i_divisor  = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    chk("done_start_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    chk("done_start_busy2", 64'(o_busy), 64'd0);
    chk("done_start_z",     o_z,         64'hFFFFFFFF_00000005);

`ifdef DIV_SIGNED_EN
    do_div(32'hFFFFFFF9, 32'd2, 0, 0, cyc, bcyc);
    chk("s_m7_2_z",       o_z,        64'hFFFFFFFD_FFFFFFFF);
    chk("s_m7_2_latency", 64'(cyc),   64'd34);
    do_div(32'h80000000, 32'hFFFFFFFF, 0, 0, cyc, bcyc);
    chk("s_ovf_z",   o_z,         64'h80000000_00000000);
    chk("s_ovf_dbz", 64'(o_dbz),  64'd0);
    // -1 / -2147483647 = 0 r -1
    do_div(32'hFFFFFFFF, 32'h80000001, 0, 0, cyc, bcyc);
    chk("s_bigdiv_z", o_z, 64'h00000000_FFFFFFFF);
`else
    do_div(32'hFFFFFFFF, 32'd1, 0, 0, cyc, bcyc);
    chk("u_max_1_z",       o_z,      64'hFFFFFFFF_00000000);
    chk("u_max_1_latency", 64'(cyc), 64'd34);
    // Divisor with the MSB set: 0xFFFFFFFF / 0x80000001 = 1 r 0x7FFFFFFE
    do_div(32'hFFFFFFFF, 32'h80000001, 0, 0, cyc, bcyc);
    chk("u_bigdiv_z",   o_z,         64'h00000001_7FFFFFFE);
    chk("u_bigdiv_dbz", 64'(o_dbz),  64'd0);
`endif

    // Re-pulse start at iteration 5. The result must stay 14 r 2.
    do_div(32'd100, 32'd7, 5, 0, cyc, bcyc);
    chk("repulse_z",       o_z,      64'h0000000E_00000002);
    chk("repulse_latency", 64'(cyc), 64'd34);

    // Reset at iteration 10 discards everything.
    do_div(32'd100, 32'd7, 0, 10, cyc, bcyc);
    @(negedge clk);
    i_reset = 1'b0;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    chk("midrst_z",    o_z,         64'd0);
    chk("midrst_dbz",  64'(o_dbz),  64'd0);

    do_div(32'd9, 32'd3, 0, 0, cyc, bcyc);
    chk("post_rst_9_3_z",       o_z,      64'h00000003_00000000);
    chk("post_rst_9_3_latency", 64'(cyc), 64'd34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
